// File: rtl/exe_stage_if.sv
// Bundle of ID/EXE-side inputs and EXE/MEM-side outputs of the execute stage.
// The slave modport is the stage itself; the master modport drives it.
interface exe_stage_if;
    logic        freeze;
    logic        WB_EN_IN;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic        B_IN;
    logic        S_IN;
    logic [3:0]  EXE_CMD_IN;
    logic        C_IN;
    logic [31:0] PC_IN;
    logic [31:0] Val_Rn_IN;
    logic [31:0] Val_Rm_IN;
    logic        imm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;

    logic        Branch_Taken;
    logic [31:0] Branch_Address;
    logic [3:0]  SR;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic [3:0]  Dest;

    modport slave (
        input  freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN, C_IN,
               PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN, Signed_imm_24_IN,
               Dest_IN,
        output Branch_Taken, Branch_Address, SR, WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res,
               Val_Rm, Dest
    );

    modport master (
        output freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN, C_IN,
               PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN, Signed_imm_24_IN,
               Dest_IN,
        input  Branch_Taken, Branch_Address, SR, WB_EN, MEM_R_EN, MEM_W_EN, ALU_Res,
               Val_Rm, Dest
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU with NZCV flags, branch target, status register
// and the EXE/MEM pipeline register.
module exe_stage (
    input logic       clk,
    input logic       rst,
    exe_stage_if.slave bus
);
    localparam logic [3:0] CmdMov = 4'b0001;
    localparam logic [3:0] CmdMvn = 4'b1001;
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;
    localparam logic [3:0] CmdAnd = 4'b0110;
    localparam logic [3:0] CmdOrr = 4'b0111;
    localparam logic [3:0] CmdEor = 4'b1000;

    logic [31:0] val2;
    logic [31:0] imm32;
    logic [63:0] imm_rot;
    logic [63:0] rm_rot;
    logic [4:0]  rot_amt;
    logic [4:0]  sh_amt;
    logic [32:0] sum33;
    logic [31:0] alu_res;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  flags;

    logic [3:0]  sr_q, sr_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic        mem_w_en_q, mem_w_en_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] val_rm_q, val_rm_d;
    logic [3:0]  dest_q, dest_d;

    // Rotations are done by shifting a doubled word and keeping the low half.
    always_comb begin
        rot_amt = {bus.Shift_operand_IN[11:8], 1'b0};
        sh_amt  = bus.Shift_operand_IN[11:7];
        imm32   = {24'b0, bus.Shift_operand_IN[7:0]};
        imm_rot = {imm32, imm32} >> rot_amt;
        rm_rot  = {bus.Val_Rm_IN, bus.Val_Rm_IN} >> sh_amt;
        val2    = bus.Val_Rm_IN;
        if (bus.imm_IN) begin
            val2 = imm_rot[31:0];
        end else if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN) begin
            val2 = {20'b0, bus.Shift_operand_IN};
        end else begin
            case (bus.Shift_operand_IN[6:5])
                2'b00:   val2 = bus.Val_Rm_IN << sh_amt;
                2'b01:   val2 = bus.Val_Rm_IN >> sh_amt;
                2'b10:   val2 = 32'($signed(bus.Val_Rm_IN) >>> sh_amt);
                default: val2 = rm_rot[31:0];
            endcase
        end
    end

    // Subtraction is Rn + ~Val2 + carry-in, so bit 32 is directly NOT borrow.
    always_comb begin
        sum33   = 33'b0;
        alu_res = 32'b0;
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        case (bus.EXE_CMD_IN)
            CmdMov: alu_res = val2;
            CmdMvn: alu_res = ~val2;
            CmdAnd: alu_res = bus.Val_Rn_IN & val2;
            CmdOrr: alu_res = bus.Val_Rn_IN | val2;
            CmdEor: alu_res = bus.Val_Rn_IN ^ val2;
            CmdAdd, CmdAdc: begin
                sum33 = {1'b0, bus.Val_Rn_IN} + {1'b0, val2}
                      + {32'b0, (bus.EXE_CMD_IN == CmdAdc) && bus.C_IN};
                alu_res = sum33[31:0];
                flag_c  = sum33[32];
                flag_v  = (bus.Val_Rn_IN[31] == val2[31]) && (sum33[31] != bus.Val_Rn_IN[31]);
            end
            CmdSub, CmdSbc: begin
                sum33 = {1'b0, bus.Val_Rn_IN} + {1'b0, ~val2}
                      + {32'b0, (bus.EXE_CMD_IN == CmdSub) || bus.C_IN};
                alu_res = sum33[31:0];
                flag_c  = sum33[32];
                flag_v  = (bus.Val_Rn_IN[31] != val2[31]) && (sum33[31] != bus.Val_Rn_IN[31]);
            end
            default: alu_res = 32'b0;
        endcase
        flags = {alu_res[31], alu_res == 32'b0, flag_c, flag_v};
    end

    assign bus.Branch_Taken   = bus.B_IN;
    assign bus.Branch_Address = bus.PC_IN
                              + {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};

    always_comb begin
        sr_d       = sr_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        dest_d     = dest_q;
        if (!bus.freeze) begin
            if (bus.S_IN) begin
                sr_d = flags;
            end
            wb_en_d    = bus.WB_EN_IN;
            mem_r_en_d = bus.MEM_R_EN_IN;
            mem_w_en_d = bus.MEM_W_EN_IN;
            alu_res_d  = alu_res;
            val_rm_d   = bus.Val_Rm_IN;
            dest_d     = bus.Dest_IN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q       <= 4'b0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= 32'b0;
            val_rm_q   <= 32'b0;
            dest_q     <= 4'b0;
        end else begin
            sr_q       <= sr_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            dest_q     <= dest_d;
        end
    end

    assign bus.SR       = sr_q;
    assign bus.WB_EN    = wb_en_q;
    assign bus.MEM_R_EN = mem_r_en_q;
    assign bus.MEM_W_EN = mem_w_en_q;
    assign bus.ALU_Res  = alu_res_q;
    assign bus.Val_Rm   = val_rm_q;
    assign bus.Dest     = dest_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: each vector has a hand-computed expected result.
module tb_exe_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.freeze           = 1'b0;
        bus.WB_EN_IN         = 1'b0;
        bus.MEM_R_EN_IN      = 1'b0;
        bus.MEM_W_EN_IN      = 1'b0;
        bus.B_IN             = 1'b0;
        bus.S_IN             = 1'b0;
        bus.EXE_CMD_IN       = 4'b0;
        bus.C_IN             = 1'b0;
        bus.PC_IN            = 32'b0;
        bus.Val_Rn_IN        = 32'b0;
        bus.Val_Rm_IN        = 32'b0;
        bus.imm_IN           = 1'b0;
        bus.Shift_operand_IN = 12'b0;
        bus.Signed_imm_24_IN = 24'b0;
        bus.Dest_IN          = 4'b0;
    endtask

    task automatic op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                      input logic imm, input logic [11:0] shop, input logic s);
        clear_in();
        bus.EXE_CMD_IN       = cmd;
        bus.Val_Rn_IN        = rn;
        bus.Val_Rm_IN        = rm;
        bus.imm_IN           = imm;
        bus.Shift_operand_IN = shop;
        bus.S_IN             = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sr"}, {28'b0, bus.SR}, 32'h0);
        check({tag, "_wb"}, {31'b0, bus.WB_EN}, 32'h0);
        check({tag, "_mr"}, {31'b0, bus.MEM_R_EN}, 32'h0);
        check({tag, "_mw"}, {31'b0, bus.MEM_W_EN}, 32'h0);
        check({tag, "_res"}, bus.ALU_Res, 32'h0);
        check({tag, "_rm"}, bus.Val_Rm, 32'h0);
        check({tag, "_dest"}, {28'b0, bus.Dest}, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_in();
        #12;
        check_all_zero("reset");
        rst = 1'b0;

        // ADD overflow into sign bit: N and V set
        op(4'b0010, 32'h7FFF_FFFF, 32'h0000_1234, 1'b1, 12'h001, 1'b1);
        bus.WB_EN_IN = 1'b1;
        bus.Dest_IN  = 4'd3;
        tick();
        check("add_res", bus.ALU_Res, 32'h8000_0000);
        check("add_sr", {28'b0, bus.SR}, 32'h9);
        check("add_rm", bus.Val_Rm, 32'h0000_1234);
        check("add_dest", {28'b0, bus.Dest}, 32'h3);
        check("add_wb", {31'b0, bus.WB_EN}, 32'h1);

        op(4'b0100, 32'd5, 32'd0, 1'b1, 12'h005, 1'b1);
        tick();
        check("sub_res", bus.ALU_Res, 32'h0);
        check("sub_sr", {28'b0, bus.SR}, 32'h6);

        // 0xFF rotated right by 8
        op(4'b0001, 32'd0, 32'd0, 1'b1, 12'h4FF, 1'b1);
        tick();
        check("mov_rot_res", bus.ALU_Res, 32'hFF00_0000);
        check("mov_rot_sr", {28'b0, bus.SR}, 32'h8);

        // ASR by 4, no S: SR must hold
        op(4'b0001, 32'd0, 32'h8000_0000, 1'b0, 12'h240, 1'b0);
        tick();
        check("asr_res", bus.ALU_Res, 32'hF800_0000);
        check("asr_sr_hold", {28'b0, bus.SR}, 32'h8);

        op(4'b0001, 32'd0, 32'h1234_5678, 1'b0, 12'h460, 1'b0);
        tick();
        check("ror_res", bus.ALU_Res, 32'h7812_3456);

        op(4'b0001, 32'd0, 32'h1234_5678, 1'b0, 12'h020, 1'b0);
        tick();
        check("lsr0_res", bus.ALU_Res, 32'h1234_5678);

        op(4'b0010, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 12'hABC, 1'b0);
        bus.MEM_R_EN_IN = 1'b1;
        tick();
        check("mem_addr", bus.ALU_Res, 32'h0000_1ABC);
        check("mem_r_en", {31'b0, bus.MEM_R_EN}, 32'h1);

        // SBC with C_IN=0 subtracts an extra one
        op(4'b0101, 32'd10, 32'd0, 1'b1, 12'h003, 1'b1);
        tick();
        check("sbc_res", bus.ALU_Res, 32'd6);
        check("sbc_sr", {28'b0, bus.SR}, 32'h2);

        op(4'b0011, 32'hFFFF_FFFF, 32'd0, 1'b1, 12'h001, 1'b1);
        bus.C_IN = 1'b1;
        tick();
        check("adc_res", bus.ALU_Res, 32'h0000_0001);
        check("adc_sr", {28'b0, bus.SR}, 32'h2);

        op(4'b1001, 32'd0, 32'd0, 1'b1, 12'h000, 1'b0);
        tick();
        check("mvn_res", bus.ALU_Res, 32'hFFFF_FFFF);

        op(4'b0110, 32'h0000_F0F0, 32'd0, 1'b1, 12'h0FF, 1'b0);
        tick();
        check("and_res", bus.ALU_Res, 32'h0000_00F0);

        op(4'b0111, 32'h0000_F000, 32'd0, 1'b1, 12'h00F, 1'b0);
        tick();
        check("orr_res", bus.ALU_Res, 32'h0000_F00F);

        op(4'b1000, 32'h0000_00FF, 32'd0, 1'b1, 12'h0F0, 1'b0);
        tick();
        check("eor_res", bus.ALU_Res, 32'h0000_000F);

        op(4'b1111, 32'h1234_5678, 32'd0, 1'b1, 12'h0FF, 1'b1);
        tick();
        check("undef_res", bus.ALU_Res, 32'h0);
        check("undef_sr", {28'b0, bus.SR}, 32'h4);

        // Branch outputs are combinational: check before any edge
        clear_in();
        bus.B_IN             = 1'b1;
        bus.PC_IN            = 32'h0000_0100;
        bus.Signed_imm_24_IN = 24'hFFFFFE;
        #1;
        check("br_taken", {31'b0, bus.Branch_Taken}, 32'h1);
        check("br_addr", bus.Branch_Address, 32'h0000_00F8);
        bus.Signed_imm_24_IN = 24'h000010;
        #1;
        check("br_addr_fwd", bus.Branch_Address, 32'h0000_0140);

        // Freeze holds everything, including SR against S_IN
        op(4'b0010, 32'd1, 32'h0000_0055, 1'b1, 12'h001, 1'b1);
        bus.WB_EN_IN = 1'b1;
        bus.Dest_IN  = 4'd7;
        bus.freeze   = 1'b1;
        tick();
        check("frz_res", bus.ALU_Res, 32'h0);
        check("frz_sr", {28'b0, bus.SR}, 32'h4);
        check("frz_dest", {28'b0, bus.Dest}, 32'h0);
        check("frz_wb", {31'b0, bus.WB_EN}, 32'h0);
        bus.freeze = 1'b0;
        tick();
        check("unfrz_res", bus.ALU_Res, 32'd2);
        check("unfrz_sr", {28'b0, bus.SR}, 32'h0);
        check("unfrz_dest", {28'b0, bus.Dest}, 32'h7);
        check("unfrz_rm", bus.Val_Rm, 32'h0000_0055);

        // Asynchronous reset between edges
        op(4'b0010, 32'd3, 32'h0000_00AA, 1'b1, 12'h004, 1'b1);
        bus.WB_EN_IN = 1'b1;
        bus.Dest_IN  = 4'd9;
        tick();
        check("pre_rst_res", bus.ALU_Res, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        #3;
        rst = 1'b0;
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
